// File: rtl/fetch_cycle_buffered_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The master issues req/addr; the slave answers with gnt and, later, rvalid/rdata.
interface fetch_cycle_buffered_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_cycle_buffered.sv
// RV32I instruction-fetch stage: PC owner, single-outstanding imem requests,
// a small fetch FIFO and the IF/ID register with stall/flush/redirect handling.
module fetch_cycle_buffered #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FBUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PCSrcE,
    input  logic [31:0]                   PCTargetE,
    input  logic                          StallD,
    input  logic                          FlushD,
    fetch_cycle_buffered_if.master        imem,
    output logic [31:0]                   InstrD,
    output logic [31:0]                   PCD,
    output logic [31:0]                   PCPlus4D,
    output logic                          ValidD
);
    localparam int PTR_W = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(FBUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FBUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic [31:0]      buf_instr [FBUF_DEPTH];
    logic [31:0]      buf_pc    [FBUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             grant;
    logic             push;
    logic             pop;
    logic             buf_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Issue only when nothing is in flight and the response is guaranteed a slot.
    assign imem.req  = rst && (state == IDLE) && (count < DEPTH_CNT);
    assign imem.addr = pc;
    assign grant     = imem.req && imem.gnt;
    assign buf_empty = (count == '0);
    assign push      = (state == WAIT) && imem.rvalid && !PCSrcE;
    assign pop       = !PCSrcE && !FlushD && !StallD && !buf_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = PCSrcE ? DROP : WAIT;
            WAIT: begin
                if (imem.rvalid)  state_nxt = IDLE;
                else if (PCSrcE)  state_nxt = DROP;
            end
            DROP: if (imem.rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (PCSrcE)     pc <= PCTargetE & ~32'd3;
            else if (grant) pc <= pc + 32'd4;

            if (PCSrcE) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) req_pc <= pc;
        if (push) begin
            buf_instr[wr_ptr] <= imem.rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

    // IF/ID register: redirect/flush bubble beats stall, stall beats pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
        end else if (PCSrcE || FlushD) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end else if (StallD) begin
            ValidD <= ValidD;
        end else if (!buf_empty) begin
            ValidD   <= 1'b1;
            InstrD   <= buf_instr[rd_ptr];
            PCD      <= buf_pc[rd_ptr];
            PCPlus4D <= buf_pc[rd_ptr] + 32'd4;
        end else begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end
    end
endmodule

// File: doc/fetch_cycle_buffered.md
Name: fetch_cycle_buffered

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It is the producer side of the IF/ID interface that the decode stage consumes (InstrD, PCD, PCPlus4D). It owns the PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and queues returned instructions in a small fetch buffer. It drives the IF/ID pipeline register and honours the hazard unit's StallD/FlushD and execute-stage branch redirects (PCSrcE/PCTargetE).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FBUF_DEPTH, 2, fetch-buffer entries; legal range 1..4.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on InstrD when ValidD=0.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-low reset.
PCSrcE  in  1  taken branch/jump from execute; redirect.
PCTargetE  in  32  redirect target; bits [1:0] ignored (forced 0).
StallD  in  1  hold IF/ID register contents.
FlushD  in  1  replace IF/ID contents with a bubble.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch word address (byte address, [1:0]=0).
imem_gnt  in  1  request accepted in the cycle imem_req&&imem_gnt.
imem_rvalid  in  1  response valid; earliest 1 cycle after grant.
imem_rdata  in  32  instruction word, valid with imem_rvalid.
InstrD  out  32  instruction to decode.
PCD  out  32  PC of InstrD.
PCPlus4D  out  32  PCD+4.
ValidD  out  1  InstrD is a real instruction (0 = bubble).

Behaviour:
- Reset (rst==0 at posedge): PC<=RESET_PC; FSM<=IDLE; buffer emptied (count=0); ValidD<=0, InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0. imem_req is forced 0 while rst==0.
- Reset mid-transaction: an outstanding response that arrives after reset is seen in IDLE and ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; response will be kept.
  - DROP: one request outstanding; response will be discarded.
- Request issue:
  - imem_req=1 only in IDLE with count<FBUF_DEPTH; imem_addr=PC.
  - On imem_req&&imem_gnt: req_pc<=PC, PC<=PC+4 (32-bit wrap), FSM<=WAIT.
  - The address is sampled only in the grant cycle; there is no hold requirement on ungranted cycles.
- Response, in WAIT on imem_rvalid: push {req_pc, imem_rdata}; FSM<=IDLE.
  - Space is guaranteed, since issue requires count<FBUF_DEPTH.
  - The next request can issue the following cycle.
- Response, in DROP on imem_rvalid: discard; FSM<=IDLE.
- imem_rvalid in IDLE: ignored.
- Redirect (PCSrcE=1), highest priority after reset:
  - PC<=PCTargetE&~3; buffer flushed (count<=0; any same-cycle push is discarded).
  - IF/ID<=bubble.
  - FSM next state:
    - WAIT without rvalid -> DROP.
    - WAIT with rvalid -> IDLE (data dropped).
    - IDLE with a grant in the same cycle -> DROP (the granted fetch is wrong-path).
    - DROP without rvalid -> remains DROP.
- IF/ID register priority per posedge:
  1. Reset.
  2. PCSrcE or FlushD -> bubble (ValidD=0, InstrD=NOP_INSTR; PCD/PCPlus4D hold).
  3. StallD -> hold all outputs; no pop.
  4. Buffer non-empty -> pop head; InstrD/PCD<=entry; PCPlus4D<=PC+4 of entry; ValidD<=1.
  5. Otherwise -> bubble.
- FlushD alone does not flush the buffer or change the PC.
- No bypass: a push becomes poppable at the next edge. Best-case latency is grant at T, rvalid at T+1, ValidD=1 after edge T+2.
- Simultaneous push and pop: count is unchanged, FIFO order is preserved, and pointers wrap modulo FBUF_DEPTH.
- Throughput: with one outstanding request, the minimum is 1 instruction per 2 cycles at 1-cycle memory latency.

Test Plan:
- Reset, then gnt=1 and rvalid one cycle after grant, returning 0x00500093 at addr 0 -> imem_addr=0 then 4; after edge T+2: InstrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1.
- StallD=1 for 5 cycles with memory responding -> IF/ID holds; exactly FBUF_DEPTH(2) fetches are granted, then imem_req=0; on release, addrs 4 and 8 pop on consecutive cycles in order.
- Grant at addr 8; PCSrcE=1 with PCTargetE=0x102 on the next cycle before rvalid -> FSM enters DROP; the late rdata is discarded; the next imem_addr is 0x100; ValidD=0 on the redirect edge.
- PCSrcE=1 in the same cycle as imem_gnt -> that response is discarded; the buffer is emptied; no stale instruction ever reaches ValidD=1.
- FlushD=1 with 2 buffered entries -> one bubble (ValidD=0, InstrD=0x00000013); the following cycles deliver both entries unchanged.
- rst=0 for one cycle while WAIT is outstanding, then rvalid arrives -> the response is ignored; the first fetch is RESET_PC; all outputs are at reset values after the reset edge.
